// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog bus master: register addresses,
// CTRL word layout, default unlock word and the sequencer/writer states.
package wd_pkg;

  // Register address map (2'b10 is the read-only status register and is
  // never driven by this block, so it has no constant here)
  localparam logic [1:0] ADDR_FWLEN = 2'b00;
  localparam logic [1:0] ADDR_SWLEN = 2'b01;
  localparam logic [1:0] ADDR_CTRL  = 2'b11;

  // CTRL word bit positions
  localparam int CTRL_WDSRVC_BIT = 0;
  localparam int CTRL_INIT_BIT   = 1;
  localparam int CTRL_RSTLMT_LSB = 8;

  localparam logic [15:0] UNLOCK_PAT_DEFAULT = 16'hA5C3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_FW,
    ST_WR_SW,
    ST_WR_INIT,
    ST_SRVC_WAIT,
    ST_WR_SRVC,
    ST_FAILED
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_UNLOCK,
    PH_DATA,
    PH_GAP
  } phase_t;

  // CTRL word: reset limit in the top byte, INIT always set, WDSRVC selectable
  function automatic logic [15:0] ctrl_word(input logic [7:0] rst_lmt, input logic srvc);
    logic [15:0] w;
    w = '0;
    w[CTRL_RSTLMT_LSB +: 8] = rst_lmt;
    w[CTRL_INIT_BIT]        = 1'b1;
    w[CTRL_WDSRVC_BIT]      = srvc;
    return w;
  endfunction

endpackage

// File: rtl/wd_bus_writer.sv
// One register write on the watchdog bus: an UNLOCK cycle, a DATA cycle,
// then GAP_CYC idle cycles. A new request on the last gap cycle chains the
// next write with no extra idle cycle; abort drops the bus to idle at once.
module wd_bus_writer
  import wd_pkg::*;
#(
  parameter logic [15:0] UNLOCK_PAT = UNLOCK_PAT_DEFAULT,
  parameter int          GAP_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        abort,
  input  logic [1:0]  addr,
  input  logic [15:0] data,
  output logic        done,
  output logic [1:0]  abus,
  output logic [15:0] dbus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC);

  phase_t      phase_q, phase_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  abus_q, abus_d;
  logic [15:0] dbus_q, dbus_d;

  assign done = (phase_q == PH_GAP) && (gap_q == GAP_LAST);
  assign abus = abus_q;
  assign dbus = dbus_q;

  // Phase sequencing and next bus value (idle bus unless a phase drives it)
  always_comb begin
    phase_d = phase_q;
    gap_d   = gap_q;
    abus_d  = 2'b00;
    dbus_d  = 16'h0000;
    if (abort) begin
      phase_d = PH_IDLE;
      gap_d   = 4'd0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (req) begin
            phase_d = PH_UNLOCK;
            dbus_d  = UNLOCK_PAT;
          end
        end
        PH_UNLOCK: begin
          phase_d = PH_DATA;
          abus_d  = addr;
          dbus_d  = data;
        end
        PH_DATA: begin
          phase_d = PH_GAP;
          gap_d   = 4'd1;
        end
        PH_GAP: begin
          if (done) begin
            gap_d = 4'd0;
            if (req) begin
              phase_d = PH_UNLOCK;
              dbus_d  = UNLOCK_PAT;
            end else begin
              phase_d = PH_IDLE;
            end
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  // Phase, gap counter and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      gap_q   <= 4'd0;
      abus_q  <= 2'b00;
      dbus_q  <= 16'h0000;
    end else begin
      phase_q <= phase_d;
      gap_q   <= gap_d;
      abus_q  <= abus_d;
      dbus_q  <= dbus_d;
    end
  end

endmodule

// File: rtl/wd_bus_master.sv
// Watchdog configure/service sequencer: programs FWLEN, SWLEN and CTRL(INIT),
// then periodically writes CTRL with WDSRVC set until STOP or a watchdog failure.
module wd_bus_master
  import wd_pkg::*;
#(
  parameter logic [15:0] UNLOCK_PAT = UNLOCK_PAT_DEFAULT,
  parameter int          GAP_CYC    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [15:0] CFG_FWLEN,
  input  logic [15:0] CFG_SWLEN,
  input  logic [7:0]  CFG_RSTLMT,
  input  logic [15:0] SRVC_PERIOD,
  input  logic        WDFAIL,
  input  logic [2:0]  FLSTAT,
  output logic [1:0]  ABUS,
  output logic [15:0] DBUS,
  output logic        BUSY,
  output logic        ARMED,
  output logic        ERR,
  output logic [2:0]  FAIL_CODE
);

  state_t      state_q, state_d;
  logic        stop_q, stop_d;
  logic        launch_q, launch_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        busy_q, busy_d, armed_q, armed_d, err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] fwlen_q, swlen_q, period_q;
  logic [7:0]  rstlmt_q;
  logic        cfg_load, stop_any, in_write;
  logic        wr_req, wr_abort, wr_done;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;

  assign stop_any = stop_q | STOP;
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign in_write = (state_q == ST_WR_FW) || (state_q == ST_WR_SW) ||
                    (state_q == ST_WR_INIT) || (state_q == ST_WR_SRVC);

  // Sequencer next state; a watchdog failure overrides everything else
  always_comb begin
    state_d  = state_q;
    stop_d   = stop_q;
    launch_d = 1'b0;
    cnt_d    = cnt_q;
    code_d   = code_q;
    cfg_load = 1'b0;
    wr_req   = launch_q;
    wr_abort = 1'b0;
    if (WDFAIL && (state_q != ST_IDLE)) begin
      state_d  = ST_FAILED;
      stop_d   = 1'b0;
      wr_req   = 1'b0;
      wr_abort = 1'b1;
      if (state_q != ST_FAILED) code_d = FLSTAT;
    end else if ((state_q == ST_IDLE) || (state_q == ST_FAILED)) begin
      if (START) begin
        state_d  = ST_WR_FW;
        launch_d = 1'b1;
        stop_d   = 1'b0;
        cfg_load = 1'b1;
      end
    end else if (state_q == ST_SRVC_WAIT) begin
      if (STOP) begin
        state_d = ST_IDLE;
      end else if (cnt_inc >= period_q) begin
        state_d = ST_WR_SRVC;
        wr_req  = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (in_write) begin
      stop_d = stop_any;
      if (wr_done) begin
        if (stop_any) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else if (state_q == ST_WR_FW) begin
          state_d = ST_WR_SW;
          wr_req  = 1'b1;
        end else if (state_q == ST_WR_SW) begin
          state_d = ST_WR_INIT;
          wr_req  = 1'b1;
        end else begin
          state_d = ST_SRVC_WAIT;
          cnt_d   = 16'd0;
        end
      end
    end else begin
      state_d = ST_IDLE;
    end
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FAILED);
    armed_d = (state_d == ST_SRVC_WAIT) || (state_d == ST_WR_SRVC);
    err_d   = (state_d == ST_FAILED);
  end

  // Address/data for the write owned by the current state
  always_comb begin
    wr_addr = ADDR_FWLEN;
    wr_data = fwlen_q;
    case (state_q)
      ST_WR_SW: begin
        wr_addr = ADDR_SWLEN;
        wr_data = swlen_q;
      end
      ST_WR_INIT: begin
        wr_addr = ADDR_CTRL;
        wr_data = ctrl_word(rstlmt_q, 1'b0);
      end
      ST_WR_SRVC: begin
        wr_addr = ADDR_CTRL;
        wr_data = ctrl_word(rstlmt_q, 1'b1);
      end
      default: ;
    endcase
  end

  // Control state and registered status outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      stop_q   <= 1'b0;
      launch_q <= 1'b0;
      cnt_q    <= 16'd0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      stop_q   <= stop_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Configuration snapshot taken when a START is accepted; a zero period runs as 1
  always_ff @(posedge CLK) begin
    if (cfg_load) begin
      fwlen_q  <= CFG_FWLEN;
      swlen_q  <= CFG_SWLEN;
      rstlmt_q <= CFG_RSTLMT;
      period_q <= (SRVC_PERIOD == 16'h0000) ? 16'h0001 : SRVC_PERIOD;
    end
  end

  wd_bus_writer #(
    .UNLOCK_PAT (UNLOCK_PAT),
    .GAP_CYC    (GAP_CYC)
  ) u_writer (
    .clk   (CLK),
    .rst_n (RST),
    .req   (wr_req),
    .abort (wr_abort),
    .addr  (wr_addr),
    .data  (wr_data),
    .done  (wr_done),
    .abus  (ABUS),
    .dbus  (DBUS)
  );

  assign BUSY      = busy_q;
  assign ARMED     = armed_q;
  assign ERR       = err_q;
  assign FAIL_CODE = code_q;

endmodule

// File: tb/tb_wd_bus_master.sv
// Scoreboard bench for wd_bus_master: a schedule-based model predicts the
// output of every cycle, a monitor compares the DUT against those predictions.
module tb_wd_bus_master;

  localparam logic [15:0] UNLOCK = 16'hA5C3;
  localparam int          GAP    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stop, wdfail;
  logic [15:0] fw, sw, per;
  logic [7:0]  rl;
  logic [2:0]  flstat;
  logic [1:0]  abus;
  logic [15:0] dbus;
  logic        busy, armed, err;
  logic [2:0]  fail_code;

  wd_bus_master dut (
    .CLK         (clk),
    .RST         (rst_n),
    .START       (start),
    .STOP        (stop),
    .CFG_FWLEN   (fw),
    .CFG_SWLEN   (sw),
    .CFG_RSTLMT  (rl),
    .SRVC_PERIOD (per),
    .WDFAIL      (wdfail),
    .FLSTAT      (flstat),
    .ABUS        (abus),
    .DBUS        (dbus),
    .BUSY        (busy),
    .ARMED       (armed),
    .ERR         (err),
    .FAIL_CODE   (fail_code)
  );

  // One planned bus cycle: wr = part of a write (STOP gets latched),
  // wt = service wait cycle, bnd = last gap cycle of a write
  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    bit          armed;
    bit          wr;
    bit          wt;
    bit          bnd;
  } ent_t;

  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    bit          busy;
    bit          armed;
    bit          err;
    logic [2:0]  code;
  } exp_t;

  ent_t        plan[$];
  exp_t        exp_q[$];
  ent_t        cur;
  int          mode;       // 0 idle, 1 running, 2 failed
  bit          stop_pend;
  logic [2:0]  m_code;
  logic [15:0] m_fw, m_sw, m_per;
  logic [7:0]  m_rl;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit chk_period = 1'b0;

  function automatic ent_t mk(logic [1:0] a, logic [15:0] d, bit arm, bit wr, bit wt, bit bnd);
    ent_t e;
    e.a = a; e.d = d; e.armed = arm; e.wr = wr; e.wt = wt; e.bnd = bnd;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_write(input logic [1:0] a, input logic [15:0] d, input bit arm);
    plan.push_back(mk(2'b00, UNLOCK, arm, 1, 0, 0));
    plan.push_back(mk(a, d, arm, 1, 0, 0));
    for (int i = 1; i <= GAP; i++) plan.push_back(mk(2'b00, 16'h0, arm, 1, 0, i == GAP));
  endtask

  task automatic add_service();
    int n;
    n = (m_per == 16'h0) ? 1 : int'(m_per);
    for (int i = 0; i < n; i++) plan.push_back(mk(2'b00, 16'h0, 1, 0, 1, 0));
    push_write(2'b11, {m_rl, 8'h03}, 1);
  endtask

  // Advance the model across the coming clock edge using the driven inputs
  task automatic model_step();
    exp_t e;
    if (!rst_n) begin
      mode = 0; stop_pend = 0; m_code = 3'd0; plan.delete();
      cur = mk(2'b00, 16'h0, 0, 0, 0, 0);
    end else if (mode != 0 && wdfail) begin
      if (mode != 2) m_code = flstat;
      mode = 2; stop_pend = 0; plan.delete();
      cur = mk(2'b00, 16'h0, 0, 0, 0, 0);
    end else if (mode != 1) begin
      if (start) begin
        m_fw = fw; m_sw = sw; m_rl = rl; m_per = per;
        plan.delete();
        plan.push_back(mk(2'b00, 16'h0, 0, 1, 0, 0));
        push_write(2'b00, m_fw, 0);
        push_write(2'b01, m_sw, 0);
        push_write(2'b11, {m_rl, 8'h02}, 0);
        mode = 1; stop_pend = 0;
        cur = plan.pop_front();
      end else begin
        cur = mk(2'b00, 16'h0, 0, 0, 0, 0);
      end
    end else begin
      if ((cur.wt && stop) || (cur.bnd && (stop || stop_pend))) begin
        mode = 0; stop_pend = 0; plan.delete();
        cur = mk(2'b00, 16'h0, 0, 0, 0, 0);
      end else begin
        if (stop && cur.wr) stop_pend = 1;
        if (plan.size() == 0) add_service();
        cur = plan.pop_front();
      end
    end
    e.a = cur.a; e.d = cur.d; e.armed = cur.armed;
    e.busy = (mode == 1); e.err = (mode == 2); e.code = m_code;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return cur.armed && cur.wr && (cur.a == 2'b11);     // service DATA cycle
      1: return cur.armed && cur.wr && (cur.d == UNLOCK);    // service UNLOCK cycle
      2: return !cur.armed && (cur.a == 2'b01);              // SWLEN DATA cycle
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_until(input int kind, input string nm);
    int n;
    n = 0;
    while (!cond(kind) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, n);
    end
  endtask

  // Monitor: compare each cycle's outputs with the oldest prediction
  initial begin
    exp_t e;
    int   last_srvc;
    last_srvc = -1;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no prediction for cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("abus", abus, e.a);
        chk("dbus", dbus, e.d);
        chk("busy", busy, e.busy);
        chk("armed", armed, e.armed);
        chk("err", err, e.err);
        chk("fail_code", fail_code, e.code);
      end
      if (chk_period && abus == 2'b11 && dbus == 16'h0503) begin
        if (last_srvc >= 0) chk("srvc_interval", cyc - last_srvc, 10 + 2 + GAP);
        last_srvc = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wdfail = 1'b0; flstat = 3'd0;
    fw = 16'h0; sw = 16'h0; rl = 8'h0; per = 16'h0;
    mode = 0; stop_pend = 0; m_code = 3'd0;
    cur = mk(2'b00, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Configure + periodic service; START on the first edge after reset release
    fw = 16'h0100; sw = 16'h0040; rl = 8'h05; per = 16'd10;
    chk_period = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    fw = 16'hDEAD; sw = 16'hBEEF; rl = 8'h77; per = 16'd2;
    repeat (70) tick();
    chk_period = 1'b0;

    // Watchdog failure on a DATA cycle
    run_until(0, "reach_srvc_data");
    flstat = 3'b101; wdfail = 1'b1; tick(); wdfail = 1'b0; flstat = 3'b000;
    repeat (20) tick();

    // START together with WDFAIL stays failed; START alone reconfigures
    start = 1'b1; wdfail = 1'b1; flstat = 3'b010; tick();
    start = 1'b0; wdfail = 1'b0; flstat = 3'b000;
    repeat (3) tick();
    fw = 16'h1234; sw = 16'h0ABC; rl = 8'hC7; per = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (30) tick();

    // STOP during a service write
    run_until(1, "reach_srvc_unlock");
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (10) tick();

    // Reset pulse during the SWLEN write
    per = 16'd3; start = 1'b1; tick(); start = 1'b0;
    run_until(2, "reach_sw_data");
    rst_n = 1'b0;
    #1;
    chk("rst_abus", abus, 2'b00);
    chk("rst_dbus", dbus, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_armed", armed, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 99) < 4);
      stop   = ($urandom_range(0, 99) < 3);
      wdfail = ($urandom_range(0, 99) < 2);
      flstat = 3'($urandom);
      fw     = 16'($urandom);
      sw     = 16'($urandom);
      rl     = 8'($urandom);
      per    = 16'($urandom_range(0, 12));
      tick();
    end
    start = 1'b0; stop = 1'b0; wdfail = 1'b0;
    repeat (3) tick();
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wd_bus_master.md
WD_BUS_MASTER -- requirements
Module: wd_bus_master

Interface
REQ-001 Parameter UNLOCK_PAT, default 16'hA5C3: unlock word that precedes every register write.
REQ-002 Parameter GAP_CYC, default 1: idle bus cycles after each write, range 1..15.
REQ-003 CLK  input  1  the single clock; all logic is rising-edge.
REQ-004 RST  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 START  input  1  one-cycle pulse; begins the configure sequence from IDLE or FAILED.
REQ-006 STOP  input  1  one-cycle pulse; ends servicing after any in-flight write completes, then returns to IDLE.
REQ-007 CFG_FWLEN  input  16  frame-window length to program.
REQ-008 CFG_SWLEN  input  16  service-window length to program.
REQ-009 CFG_RSTLMT  input  8  reset-pulse limit to program.
REQ-010 SRVC_PERIOD  input  16  cycles from the end of one service write to the start of the next.
REQ-011 WDFAIL  input  1  watchdog failure flag.
REQ-012 FLSTAT  input  3  watchdog failure status code.
REQ-013 ABUS  output  2  watchdog address bus.
REQ-014 DBUS  output  16  watchdog data bus.
REQ-015 BUSY  output  1  high in every state except IDLE and FAILED.
REQ-016 ARMED  output  1  high while in SRVC_WAIT or servicing.
REQ-017 ERR  output  1  high in FAILED.
REQ-018 FAIL_CODE  output  3  FLSTAT captured on entry to FAILED.

Function
REQ-019 Each register write takes exactly 2 cycles, then GAP_CYC idle cycles.
REQ-020 Write cycle 1: DBUS = UNLOCK_PAT, ABUS = 2'b00.
REQ-021 Write cycle 2: ABUS = target address, DBUS = data.
REQ-022 Idle bus: ABUS = 2'b00 and DBUS = 16'h0000.
REQ-023 Address map: 2'b00 = FWLEN; 2'b01 = SWLEN; 2'b10 = status, which is never written; 2'b11 = CTRL.
REQ-024 CTRL word: bit0 = WDSRVC, bit1 = INIT, bits[15:8] = RST_LMT, all other bits 0.
REQ-025 States: IDLE, WR_FW, WR_SW, WR_INIT, SRVC_WAIT, WR_SRVC, FAILED; each WR_* state has internal phases UNLOCK, DATA and GAP.
REQ-026 IDLE goes to WR_FW on START.
REQ-027 WR_FW goes to WR_SW when its gap ends.
REQ-028 WR_SW goes to WR_INIT when its gap ends.
REQ-029 WR_INIT goes to SRVC_WAIT when its gap ends.
REQ-030 SRVC_WAIT goes to WR_SRVC when the period counter reaches SRVC_PERIOD.
REQ-031 WR_SRVC goes to SRVC_WAIT when its gap ends.
REQ-032 WR_INIT writes CTRL = {CFG_RSTLMT, 6'b0, INIT=1, WDSRVC=0}.
REQ-033 WR_SRVC writes CTRL = {CFG_RSTLMT, 6'b0, INIT=1, WDSRVC=1}.
REQ-034 All CFG_* and SRVC_PERIOD inputs are sampled on START; later changes are ignored until the next START.
REQ-035 The period counter is 16-bit, clears on entry to SRVC_WAIT and increments each cycle in SRVC_WAIT.
REQ-036 SRVC_PERIOD = 0 is treated as 1.
REQ-037 The period counter saturates and never wraps.
REQ-038 WDFAIL = 1 in any state except IDLE moves to FAILED on the next edge; an in-flight write is aborted and the bus goes idle immediately.
REQ-039 FAIL_CODE captures FLSTAT on the FAILED entry edge.
REQ-040 FAILED is left only by START, which goes to WR_FW and clears ERR; FAIL_CODE holds its value.
REQ-041 WDFAIL and START in the same cycle: WDFAIL wins.
REQ-042 STOP and WDFAIL in the same cycle: WDFAIL wins.
REQ-043 START while BUSY is ignored.
REQ-044 STOP in SRVC_WAIT goes to IDLE on the next edge.
REQ-045 STOP during WR_SRVC is latched; the write and its gap complete, then the block goes to IDLE.
REQ-046 STOP during WR_FW, WR_SW or WR_INIT is latched and acted on when that write's gap ends.
REQ-047 All outputs are registered; no combinational path from any input to ABUS or DBUS.

Reset
REQ-048 RST = 0 forces state IDLE, ABUS = 0, DBUS = 0, BUSY = 0, ARMED = 0, ERR = 0, FAIL_CODE = 0, counters = 0 and the STOP latch cleared.
REQ-049 Reset asserted mid-write abandons the write with no partial cycle.
REQ-050 The first write begins no earlier than the second edge after RST deasserts.

Structure
REQ-051 A shared package wd_pkg holds the address constants, CTRL bit positions, default UNLOCK_PAT and the state enumeration.
REQ-052 One sub-module, wd_bus_writer, implements the UNLOCK/DATA/GAP write sequencing with req/addr/data inputs and a done output; wd_bus_master is the sequencer FSM.

Verification
REQ-053 START with FWLEN = 16'h0100, SWLEN = 16'h0040, RSTLMT = 8'h05 -> bus shows A5C3/00:0100, A5C3/01:0040, A5C3/11:0502 in order, each write 2 cycles followed by 1 idle cycle.
REQ-054 SRVC_PERIOD = 10 -> CTRL = 16'h0503 writes repeat every 10 + 2 + 1 cycles while ARMED = 1.
REQ-055 WDFAIL = 1 with FLSTAT = 3'b101 on a write's DATA cycle -> bus idle and ERR = 1 next cycle, FAIL_CODE = 3'b101, no further writes.
REQ-056 START and WDFAIL asserted in the same cycle from FAILED -> block remains in FAILED; a later START alone -> reconfigure sequence runs and ERR = 0.
REQ-057 STOP during WR_SRVC -> that write completes, then BUSY = 0 and ARMED = 0.
REQ-058 RST pulsed low during WR_SW -> all outputs zero immediately; after release the block stays IDLE until START.
